alu_mb_seq: RTL and testbench
=============================

Name: alu_mb_seq

Overview:
- Multi-byte arithmetic sequencer wrapped around the 8-bit ALU.
- Holds two small operand buffers and one result buffer. Executes N-byte ADD/SUB by driving the ALU one byte per cycle, LSB first, and chaining the ALU C flag into C_in.
- Produces final flags for the whole word. Sits between the control unit/register file and the ALU: it feeds the ALU's a, b, alu_op, C_in and consumes out, P, Z, S, C, OV.

Parameters:
- W, 8, ALU data width in bits; must match the ALU's ALU_rozm_data.
- MAX_BYTES, 4, operand buffer depth in bytes (maximum word length).
- OP_ADD, 3'd4, alu_op code for add-with-carry.
- OP_SUB, 3'd5, alu_op code for subtract-with-borrow.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  operand buffer write strobe
- wr_sel  in  1  0 = buffer A, 1 = buffer B
- wr_addr  in  $clog2(MAX_BYTES)  byte index, 0 = LSB
- wr_data  in  W  operand byte
- start  in  1  one-cycle request to begin an operation
- op_sub  in  1  0 = ADD, 1 = SUB; sampled with start
- len  in  $clog2(MAX_BYTES+1)  byte count; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- rd_addr  in  $clog2(MAX_BYTES)  result byte index
- rd_data  out  W  result byte; combinational read
- f_p, f_z, f_s, f_c, f_ov  out  1 each  final word flags
- alu_a, alu_b  out  W  to ALU a, b
- alu_op  out  3  to ALU alu_op
- alu_c_in  out  1  to ALU C_in
- alu_out  in  W  from ALU out
- alu_p, alu_z, alu_s, alu_c, alu_ov  in  1 each  from ALU flags

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; busy=0, done=0; all f_* = 0; byte index=0; alu_c_in=0. alu_a, alu_b and alu_op are 0 in IDLE. Buffer contents are not cleared.
- FSM states:
  - IDLE: start=1 latches op_sub and eff_len = min(len, MAX_BYTES), clears index, then moves to RUN. busy rises the next cycle.
    - If eff_len = 0, go to DONE instead: f_z=1, other flags 0, result buffer untouched.
  - RUN, byte i:
    - Drive alu_a=A[i], alu_b=B[i], and alu_op=OP_SUB if op_sub else OP_ADD.
    - alu_c_in = 0 when i=0; otherwise it is the registered alu_c from byte i-1.
    - At the clock edge: R[i] <= alu_out; carry register <= alu_c; z_acc <= z_acc & alu_z (z_acc starts at 1).
    - After i = eff_len-1, go to DONE.
  - DONE:
    - f_z = z_acc.
    - f_c, f_s, f_ov and f_p come from the last (most significant) byte's ALU flags.
    - done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: start to done pulse is eff_len+1 cycles. busy is high for eff_len cycles.
- Flag persistence: f_* hold until the next completion or until reset.
- start while busy=1 or in DONE is ignored; no queuing.
- wr_en while busy=1 is ignored, so operands stay stable during an operation. Writes in IDLE/DONE take effect next cycle.
- A write and a start in the same IDLE cycle: the write lands first and the operation uses the new byte.
- rd_data = R[rd_addr] at any time. A read during RUN returns partially updated data. An out-of-range rd_addr returns 0.
- Reset mid-RUN: return to IDLE next edge, flags 0, no done pulse. Partially written R bytes remain.

Optional Feature:
- Macro: ALU_MB_SEQ_CARRY_IN_EN.
- When defined: add input port c_in (1 bit), sampled with start and used as alu_c_in for byte 0. This supports chained ADC/SBB across operations.
- When undefined: port absent; byte 0 uses C_in=0.

Test Plan:
1. A=0x01FF, B=0x0001, ADD, len=2 -> R=0x0200, f_c=0, f_z=0, f_ov=0. done exactly 3 cycles after start; carry propagated into byte 1.
2. A=0x7FFF, B=0x0001, ADD, len=2 -> R=0x8000, f_s=1, f_ov=1, f_z=0.
3. A=0xFFFF, B=0x0001, ADD, len=2 -> R=0x0000, f_z=1, f_c=1. Also A=0x0100, B=0x0000, len=2 -> f_z=0, even though byte 0 is zero.
4. SUB A=0x0100, B=0x0001, len=2 -> R=0x00FF, f_z=0. SUB A=B=0x1234 -> R=0x0000, f_z=1.
5. start pulsed again mid-RUN and wr_en during RUN -> both ignored; result is unchanged from a clean run. len=0 -> done 1 cycle after start, f_z=1. len=7 -> clamped to 4 bytes.
6. rst asserted in the 2nd RUN cycle of a len=4 add -> next cycle busy=0, all f_*=0, no done pulse. A following clean len=1 run (0x05+0x04) -> R[0]=0x09. With ALU_MB_SEQ_CARRY_IN_EN and c_in=1 -> R[0]=0x0A.

Source files
------------

// File: rtl/alu_mb_seq_if.sv
// Host-side bus of the multi-byte ALU sequencer: operand writes, start/len, result reads, word flags.
interface alu_mb_seq_if #(
   parameter int W         = 8,
   parameter int MAX_BYTES = 4
);
   localparam int AW = $clog2(MAX_BYTES);
   localparam int LW = $clog2(MAX_BYTES + 1);

   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          start;
   logic          op_sub;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          f_p, f_z, f_s, f_c, f_ov;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, op_sub, len, rd_addr,
      input  busy, done, rd_data, f_p, f_z, f_s, f_c, f_ov
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, op_sub, len, rd_addr,
      output busy, done, rd_data, f_p, f_z, f_s, f_c, f_ov
   );
endinterface

// File: rtl/alu_mb_seq.sv
// Multi-byte ADD/SUB sequencer driving an 8-bit ALU one byte per cycle, LSB first, carry chained.
// Optional macro ALU_MB_SEQ_CARRY_IN_EN adds input c_in, used as the carry into byte 0.
module alu_mb_seq #(
   parameter int         W         = 8,
   parameter int         MAX_BYTES = 4,
   parameter logic [2:0] OP_ADD    = 3'd4,
   parameter logic [2:0] OP_SUB    = 3'd5
) (
   input  logic         clk,
   input  logic         rst,
`ifdef ALU_MB_SEQ_CARRY_IN_EN
   input  logic         c_in,
`endif
   alu_mb_seq_if.slave  bus,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_op,
   output logic         alu_c_in,
   input  logic [W-1:0] alu_out,
   input  logic         alu_p,
   input  logic         alu_z,
   input  logic         alu_s,
   input  logic         alu_c,
   input  logic         alu_ov
);
   localparam int AW = $clog2(MAX_BYTES);
   localparam int LW = $clog2(MAX_BYTES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BYTES);

   logic [1:0]    state;
   logic [AW-1:0] idx;
   logic [LW-1:0] eff_len;
   logic [LW-1:0] len_clamped;
   logic          op_sub_q;
   logic          carry_q;
   logic          z_acc;
   logic          last_byte;
   logic          start_c_in;
   logic          wr_in_range;
   logic          rd_in_range;
   logic          f_p, f_z, f_s, f_c, f_ov;

   logic [W-1:0]  buf_a [MAX_BYTES];
   logic [W-1:0]  buf_b [MAX_BYTES];
   logic [W-1:0]  buf_r [MAX_BYTES];

`ifdef ALU_MB_SEQ_CARRY_IN_EN
   assign start_c_in = c_in;
`else
   assign start_c_in = 1'b0;
`endif

   // Address range checks only matter when MAX_BYTES leaves unused index codes.
   if ((1 << AW) == MAX_BYTES) begin : g_full_range
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
   end else begin : g_part_range
      assign wr_in_range = (int'(bus.wr_addr) < MAX_BYTES);
      assign rd_in_range = (int'(bus.rd_addr) < MAX_BYTES);
   end

   assign len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
   assign last_byte   = ((LW'(idx) + LW'(1)) == eff_len);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         eff_len  <= '0;
         op_sub_q <= 1'b0;
         carry_q  <= 1'b0;
         z_acc    <= 1'b1;
         {f_p, f_z, f_s, f_c, f_ov} <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_sub_q <= bus.op_sub;
                  eff_len  <= len_clamped;
                  idx      <= '0;
                  carry_q  <= start_c_in;
                  z_acc    <= 1'b1;
                  if (len_clamped == '0) begin
                     state <= S_DONE;
                     {f_p, f_z, f_s, f_c, f_ov} <= 5'b01000;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               carry_q <= alu_c;
               z_acc   <= z_acc & alu_z;
               if (last_byte) begin
                  state <= S_DONE;
                  f_p   <= alu_p;
                  f_z   <= z_acc & alu_z;
                  f_s   <= alu_s;
                  f_c   <= alu_c;
                  f_ov  <= alu_ov;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: the byte buffers are plain storage with no reset; contents survive rst by design.
   always_ff @(posedge clk) begin
      if (bus.wr_en && (state != S_RUN) && wr_in_range) begin
         if (bus.wr_sel) buf_b[bus.wr_addr] <= bus.wr_data;
         else            buf_a[bus.wr_addr] <= bus.wr_data;
      end
      if ((state == S_RUN) && !rst) buf_r[idx] <= alu_out;
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_op   = 3'd0;
      alu_c_in = 1'b0;
      if (state == S_RUN) begin
         alu_a    = buf_a[idx];
         alu_b    = buf_b[idx];
         alu_op   = op_sub_q ? OP_SUB : OP_ADD;
         alu_c_in = carry_q;
      end
   end

   assign bus.busy    = (state == S_RUN);
   assign bus.done    = (state == S_DONE);
   assign bus.rd_data = rd_in_range ? buf_r[bus.rd_addr] : '0;
   assign bus.f_p     = f_p;
   assign bus.f_z     = f_z;
   assign bus.f_s     = f_s;
   assign bus.f_c     = f_c;
   assign bus.f_ov    = f_ov;
endmodule

// File: tb/tb_alu_mb_seq.sv
// Self-checking bench for alu_mb_seq: byte-level ALU stand-in, word-level reference model, per-cycle compare.
module tb_alu_mb_seq;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int AW = 2;
  localparam int LW = 3;
`ifdef ALU_MB_SEQ_CARRY_IN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  typedef struct packed {logic p; logic z; logic s; logic c; logic ov;} flags_t;
  typedef struct packed {logic [7:0] out; logic p; logic z; logic s; logic c; logic ov;} alu_res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mb_seq_if #(.W(W), .MAX_BYTES(MB)) bus ();

  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_op;
  logic         alu_c_in, alu_p, alu_z, alu_s, alu_c, alu_ov;
`ifdef ALU_MB_SEQ_CARRY_IN_EN
  logic         c_in;
`endif

  alu_mb_seq #(.W(W), .MAX_BYTES(MB)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef ALU_MB_SEQ_CARRY_IN_EN
    .c_in    (c_in),
`endif
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_c_in(alu_c_in),
    .alu_out (alu_out),
    .alu_p   (alu_p),
    .alu_z   (alu_z),
    .alu_s   (alu_s),
    .alu_c   (alu_c),
    .alu_ov  (alu_ov)
  );

  // 8-bit ALU stand-in: op 4 = add-with-carry, op 5 = subtract-with-borrow (C = borrow out).
  function automatic alu_res_t alu_eval(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic cin);
    alu_res_t r = '0;
    int full;
    int sres;
    int sa = $signed(a);
    int sb = $signed(b);
    if (op == 3'd4) begin
      full = int'(a) + int'(b) + int'(cin);
      sres = sa + sb + int'(cin);
      r.out = full[7:0];
      r.c = (full > 255);
      r.ov = (sres > 127) || (sres < -128);
    end else if (op == 3'd5) begin
      full = int'(a) - int'(b) - int'(cin);
      sres = sa - sb - int'(cin);
      r.out = full[7:0];
      r.c = (full < 0);
      r.ov = (sres > 127) || (sres < -128);
    end
    r.p = ^r.out;
    r.z = (r.out == 8'h00);
    r.s = r.out[7];
    return r;
  endfunction

  assign {alu_out, alu_p, alu_z, alu_s, alu_c, alu_ov} = alu_eval(alu_a, alu_b, alu_op, alu_c_in);

  // ---------------- reference model (word level) ----------------
  int     cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_a [MB];
  logic [7:0] m_b [MB];
  logic [7:0] m_r [MB];
  bit         r_known [MB];
  int         run_lo = 1, run_hi = 0, done_cyc = -1, clear_cyc = -1;
  bit         pend_valid = 1'b0;
  int         pend_cyc = -1;
  flags_t     pend_f = '0;
  flags_t     exp_f = '0;
  bit         chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_run(input int c);
    return (c >= run_lo) && (c <= run_hi);
  endfunction

  function automatic void apply_start(input bit sub, input int len, input bit cin, input int s);
    int     n = (len > MB) ? MB : len;
    longint ua = 0, ub = 0, full, res, sa, sb, sr, half, mask;
    bit     ci = cin & CIN_EN;
    flags_t f = '0;
    run_lo = s + 1;
    run_hi = s + n;
    done_cyc = s + n + 1;
    pend_valid = 1'b1;
    pend_cyc = s + n + 1;
    if (n == 0) begin
      f.z = 1'b1;
      pend_f = f;
      return;
    end
    for (int i = 0; i < n; i++) begin
      ua |= longint'(m_a[i]) << (8 * i);
      ub |= longint'(m_b[i]) << (8 * i);
    end
    mask = (longint'(1) << (8 * n)) - 1;
    half = longint'(1) << (8 * n - 1);
    sa = (ua ^ half) - half;
    sb = (ub ^ half) - half;
    if (!sub) begin
      full = ua + ub + longint'(ci);
      sr = sa + sb + longint'(ci);
      f.c = (full > mask);
    end else begin
      full = ua - ub - longint'(ci);
      sr = sa - sb - longint'(ci);
      f.c = (full < 0);
    end
    res = full & mask;
    f.ov = (sr >= half) || (sr < -half);
    f.z = (res == 0);
    f.s = ((res >> (8 * n - 1)) & 1) != 0;
    f.p = ^8'(res >> (8 * (n - 1)));
    for (int i = 0; i < n; i++) begin
      m_r[i] = 8'(res >> (8 * i));
      r_known[i] = 1'b1;
    end
    pend_f = f;
  endfunction

  // ---------------- compare process ----------------
  initial begin : compare
    wait (chk_en);
    forever begin
      @(negedge clk);
      if (pend_valid && (cyc == pend_cyc)) begin
        exp_f = pend_f;
        pend_valid = 1'b0;
      end
      if (cyc == clear_cyc) exp_f = '0;
      check("busy", 64'(bus.busy), 64'(in_run(cyc)));
      check("done", 64'(bus.done), 64'(cyc == done_cyc));
      check("flags{p,z,s,c,ov}", 64'({bus.f_p, bus.f_z, bus.f_s, bus.f_c, bus.f_ov}), 64'(exp_f));
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle of stimulus; called just after a rising edge, returns just after the next one.
  task automatic cycle(input bit we, input bit sel, input int addr, input logic [7:0] data,
                       input bit st, input bit sub, input int len, input bit cin);
    bus.wr_en   = we;
    bus.wr_sel  = sel;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    bus.start   = st;
    bus.op_sub  = sub;
    bus.len     = LW'(len);
`ifdef ALU_MB_SEQ_CARRY_IN_EN
    c_in = cin;
`endif
    if (we && !in_run(cyc)) begin
      if (sel) m_b[addr] = data;
      else     m_a[addr] = data;
    end
    if (st && !in_run(cyc) && (cyc != done_cyc)) apply_start(sub, len, cin, cyc);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask

  // Writes both operands (last B byte in the same cycle as start) and waits out the operation.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sub, input int len,
                        input bit cin, input bit disturb);
    int n = (len > MB) ? MB : len;
    for (int i = 0; i < MB; i++) cycle(1'b1, 1'b0, i, a[8*i +: 8], 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < MB - 1; i++) cycle(1'b1, 1'b1, i, b[8*i +: 8], 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, MB - 1, b[31:24], 1'b1, sub, len, cin);
    if (disturb && n > 0) begin
      cycle(1'b1, 1'b0, 0, 8'hEE, 1'b1, ~sub, 4, 1'b0);
      idle(n);
    end else begin
      idle(n + 1);
    end
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i < MB; i++) begin
      if (r_known[i]) begin
        bus.rd_addr = AW'(i);
        #1;
        check($sformatf("%s_r%0d", tag, i), 64'(bus.rd_data), 64'(m_r[i]));
      end
    end
    idle(1);
  endtask

  task automatic read_word(input int n, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      bus.rd_addr = AW'(i);
      #1;
      w[8*i +: 8] = bus.rd_data;
    end
    idle(1);
  endtask

  logic [31:0] word;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.len = '0; bus.rd_addr = '0;
`ifdef ALU_MB_SEQ_CARRY_IN_EN
    c_in = 1'b0;
`endif
    for (int i = 0; i < MB; i++) r_known[i] = 1'b0;
    idle(3);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // 1: carry propagates into byte 1
    run_op(32'h01FF, 32'h0001, 1'b0, 2, 1'b0, 1'b0);
    check_result("t1");
    read_word(2, word);
    check("t1_word", 64'(word), 64'h0200);
    check("t1_fc", 64'(bus.f_c), 64'd0);
    check("t1_fz", 64'(bus.f_z), 64'd0);
    check("t1_fov", 64'(bus.f_ov), 64'd0);

    // 2: signed overflow
    run_op(32'h7FFF, 32'h0001, 1'b0, 2, 1'b0, 1'b0);
    read_word(2, word);
    check("t2_word", 64'(word), 64'h8000);
    check("t2_fs_fov_fz", 64'({bus.f_s, bus.f_ov, bus.f_z}), 64'b110);

    // 3: wrap to zero, then a zero low byte that must not set f_z
    run_op(32'hFFFF, 32'h0001, 1'b0, 2, 1'b0, 1'b0);
    read_word(2, word);
    check("t3_word", 64'(word), 64'h0000);
    check("t3_fz_fc", 64'({bus.f_z, bus.f_c}), 64'b11);
    run_op(32'h0100, 32'h0000, 1'b0, 2, 1'b0, 1'b0);
    check("t3b_fz", 64'(bus.f_z), 64'd0);

    // 4: subtraction with borrow chain, equal operands
    run_op(32'h0100, 32'h0001, 1'b1, 2, 1'b0, 1'b0);
    read_word(2, word);
    check("t4_word", 64'(word), 64'h00FF);
    check("t4_fz", 64'(bus.f_z), 64'd0);
    run_op(32'h1234, 32'h1234, 1'b1, 2, 1'b0, 1'b0);
    read_word(2, word);
    check("t4b_word", 64'(word), 64'h0000);
    check("t4b_fz", 64'(bus.f_z), 64'd1);

    // 5: start and write during RUN ignored; len=0; len clamped
    run_op(32'h01FF, 32'h0001, 1'b0, 2, 1'b0, 1'b1);
    check_result("t5");
    read_word(2, word);
    check("t5_word", 64'(word), 64'h0200);
    run_op(32'h5555, 32'h3333, 1'b0, 0, 1'b0, 1'b0);
    check_result("t5_len0");
    check("t5_len0_flags", 64'({bus.f_p, bus.f_z, bus.f_s, bus.f_c, bus.f_ov}), 64'b01000);
    run_op(32'h80000001, 32'h80000001, 1'b0, 7, 1'b0, 1'b0);
    read_word(4, word);
    check("t5_len7_word", 64'(word), 64'h00000002);
    check("t5_len7_fc_fov", 64'({bus.f_c, bus.f_ov}), 64'b11);

    // 6: reset in the 2nd RUN cycle of a 4-byte add
    for (int i = 0; i < MB; i++) cycle(1'b1, 1'b0, i, 8'h11 * (i + 1), 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < MB; i++) cycle(1'b1, 1'b1, i, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 4, 1'b0);
    idle(1);
    rst = 1'b1;
    run_hi = cyc;
    done_cyc = -1;
    pend_valid = 1'b0;
    clear_cyc = cyc + 1;
    for (int i = 1; i < MB; i++) r_known[i] = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);
    check_result("t6_partial");
    run_op(32'h05, 32'h04, 1'b0, 1, 1'b1, 1'b0);
    read_word(1, word);
    check("t6_byte0", 64'(word), CIN_EN ? 64'h0A : 64'h09);

    // randomized operations against the word-level model
    for (int k = 0; k < 40; k++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      check_result($sformatf("rnd%0d", k));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
